// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants, state encoding and helpers for the RV32M multiply/divide sequencer
package mdu_pkg;
    localparam int XLEN = 32;
    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;
    localparam logic [XLEN-1:0] DIV_ZERO_Q  = '1;
    localparam logic [XLEN-1:0] DIV_OVF_RS1 = 32'h8000_0000;
    localparam logic [XLEN-1:0] DIV_OVF_Q   = 32'h8000_0000;
    localparam logic [XLEN-1:0] DIV_OVF_R   = '0;
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} mdu_state_e;
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? -x : x;
    endfunction
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: 32-step restoring divider on unsigned magnitudes
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_start              : load dividend/divisor and begin iterating
//   i_flush              : abandon the current division
//   i_dividend, i_divisor: unsigned operands sampled on i_start
//   o_quo, o_rem         : quotient/remainder, valid the cycle after o_last
//   o_last               : high during the final iteration cycle
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quo,
    output logic [XLEN-1:0] o_rem,
    output logic            o_last
);
    logic [XLEN-1:0] r_rem, r_quo, r_dvs;
    logic [4:0]      r_cnt;
    logic            r_run;
    logic [XLEN:0]   w_shift, w_diff;
    // the quotient register doubles as the dividend shift register
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    // w_shift < 2*divisor, so the 33-bit difference never overflows and bit 32 is its sign
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign o_last  = r_run && (r_cnt == 5'd31);
    assign o_quo   = r_quo;
    assign o_rem   = r_rem;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_flush) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_rem <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], !w_diff[XLEN]};
            r_cnt <= r_cnt + 5'd1;
            r_run <= !o_last;
        end
    end
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV32M multiply/divide sequencer with request/response handshakes
//   i_clk, i_rst_n                   : clock, async active-low reset
//   i_req_valid/o_req_ready          : request handshake from decode
//   i_req_funct3, i_req_rs1/rs2/rd   : operation select, operands, destination tag
//   o_rsp_valid/i_rsp_ready          : response handshake
//   o_rsp_data, o_rsp_rd             : result and its tag
//   o_busy                           : pipeline stall while an operation is in flight
//   i_flush                          : synchronous abort, drops any pending response
module mdu_seq
    import mdu_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [2:0]      i_req_funct3,
    input  logic [XLEN-1:0] i_req_rs1,
    input  logic [XLEN-1:0] i_req_rs2,
    input  logic [4:0]      i_req_rd,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [XLEN-1:0] o_rsp_data,
    output logic [4:0]      o_rsp_rd,
    output logic            o_busy,
    input  logic            i_flush
);
    mdu_state_e              r_state, w_next;
    logic [2:0]              r_f3;
    logic [4:0]              r_rd;
    logic [XLEN-1:0]         r_rs1, r_rs2, r_data;
    logic                    r_neg_q, r_neg_r;
    logic                    w_accept, w_signed_div, w_dz, w_ovf, w_special, w_start, w_last;
    logic                    w_sx1, w_sx2;
    logic [XLEN-1:0]         w_special_data, w_quo, w_rem, w_q_fix, w_r_fix;
    logic signed [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
    assign o_req_ready    = (r_state == S_IDLE) && !i_flush;
    assign o_rsp_valid    = (r_state == S_DONE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_rsp_data     = r_data;
    assign o_rsp_rd       = r_rd;
    assign w_accept       = i_req_valid && o_req_ready;
    // div and rem are the signed divide ops (funct3 bit 0 clear)
    assign w_signed_div   = !i_req_funct3[0];
    assign w_dz           = (i_req_rs2 == '0);
    assign w_ovf          = w_signed_div && (i_req_rs1 == DIV_OVF_RS1) && (i_req_rs2 == '1);
    assign w_special      = i_req_funct3[2] && (w_dz || w_ovf);
    assign w_special_data = w_dz ? (i_req_funct3[1] ? i_req_rs1 : DIV_ZERO_Q)
                                 : (i_req_funct3[1] ? DIV_OVF_R : DIV_OVF_Q);
    assign w_start        = w_accept && i_req_funct3[2] && !w_special;
    // operands widened to 64 bits give the same low 64 product bits as a 33x33 signed multiply
    assign w_sx1          = (r_f3 != MDU_MULHU);
    assign w_sx2          = (r_f3 == MDU_MUL) || (r_f3 == MDU_MULH);
    assign w_mul_a        = {{XLEN{w_sx1 && r_rs1[XLEN-1]}}, r_rs1};
    assign w_mul_b        = {{XLEN{w_sx2 && r_rs2[XLEN-1]}}, r_rs2};
    assign w_prod         = w_mul_a * w_mul_b;
    assign w_q_fix        = r_neg_q ? -w_quo : w_quo;
    assign w_r_fix        = r_neg_r ? -w_rem : w_rem;
    mdu_div_core u_div (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (w_start),
        .i_flush    (i_flush),
        .i_dividend (w_signed_div ? mag(i_req_rs1) : i_req_rs1),
        .i_divisor  (w_signed_div ? mag(i_req_rs2) : i_req_rs2),
        .o_quo      (w_quo),
        .o_rem      (w_rem),
        .o_last     (w_last)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = !i_req_funct3[2] ? S_MUL : (w_special ? S_DONE : S_DIV);
            S_MUL:   w_next = S_DONE;
            S_DIV:   w_next = w_last ? S_FIX : S_DIV;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = i_rsp_ready ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (i_flush) w_next = S_IDLE;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_f3    <= '0;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_data  <= '0;
        end else begin
            if (w_accept) begin
                r_f3    <= i_req_funct3;
                r_rd    <= i_req_rd;
                r_rs1   <= i_req_rs1;
                r_rs2   <= i_req_rs2;
                r_neg_q <= w_signed_div && (i_req_rs1[XLEN-1] ^ i_req_rs2[XLEN-1]);
                r_neg_r <= w_signed_div && i_req_rs1[XLEN-1];
                if (w_special) r_data <= w_special_data;
            end
            if (r_state == S_MUL) r_data <= (r_f3 == MDU_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
            if (r_state == S_FIX) r_data <= r_f3[1] ? w_r_fix : w_q_fix;
        end
    end
endmodule
